// File: rtl/maxnet_pkg.sv
// Shared definitions for the maxnet iteration controller: default sizes,
// lane count and the 3-bit controller state encoding.
package maxnet_pkg;

   localparam int DW_DEF       = 5;
   localparam int MAX_ITER_DEF = 15;
   localparam int IW_DEF       = 4;
   localparam int NLANES       = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_MULT  = 3'd1;
   localparam state_t ST_ADD   = 3'd2;
   localparam state_t ST_WRITE = 3'd3;
   localparam state_t ST_CHECK = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/maxnet_nz_encoder.sv
// Counts the lanes whose zero flag is clear, reports the lowest such lane
// and whether exactly one lane survives.
module nz_encoder
   import maxnet_pkg::*;
(
   input  logic [3:0] zf,
   output logic [2:0] nz,
   output logic [1:0] idx,
   output logic       one_hot
);

   // population count of surviving lanes and lowest surviving index
   always_comb begin
      nz = 3'(~zf[0]) + 3'(~zf[1]) + 3'(~zf[2]) + 3'(~zf[3]);
      if (!zf[0]) begin
         idx = 2'd0;
      end else if (!zf[1]) begin
         idx = 2'd1;
      end else if (!zf[2]) begin
         idx = 2'd2;
      end else if (!zf[3]) begin
         idx = 2'd3;
      end else begin
         idx = 2'd0;
      end
      one_hot = (nz == 3'd1);
   end

endmodule

// File: rtl/maxnet_ctrl.sv
// Maxnet iteration controller: holds the four neuron values, sequences the
// PU register enables, writes back results and detects convergence/timeout.
module maxnet_ctrl
   import maxnet_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int MAX_ITER = MAX_ITER_DEF,
   parameter int IW       = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] init0,
   input  logic [DW-1:0] init1,
   input  logic [DW-1:0] init2,
   input  logic [DW-1:0] init3,
   input  logic [DW-1:0] pu_new0,
   input  logic [DW-1:0] pu_new1,
   input  logic [DW-1:0] pu_new2,
   input  logic [DW-1:0] pu_new3,
   input  logic          pu_zero0,
   input  logic          pu_zero1,
   input  logic          pu_zero2,
   input  logic          pu_zero3,
   output logic [DW-1:0] x0,
   output logic [DW-1:0] x1,
   output logic [DW-1:0] x2,
   output logic [DW-1:0] x3,
   output logic          mult_reg_en,
   output logic          add_reg_en,
   output logic          busy,
   output logic          done,
   output logic [1:0]    winner,
   output logic          winner_valid,
   output logic          timeout,
   output logic [IW-1:0] iter_count
);

   localparam logic [IW-1:0] MAX_ITER_C = IW'(MAX_ITER);

   logic [DW-1:0] init_s   [NLANES];
   logic [DW-1:0] pu_new_s [NLANES];
   logic [3:0]    pu_zero_s;

   state_t        state_q, state_d;
   logic [DW-1:0] x_q [NLANES];
   logic [DW-1:0] x_d [NLANES];
   logic [3:0]    zf_q, zf_d;
   logic [IW-1:0] iter_q, iter_d;
   logic [1:0]    winner_q, winner_d;
   logic          wv_q, wv_d;
   logic          to_q, to_d;
   logic          mult_q, mult_d;
   logic          add_q, add_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   logic [2:0]    nz_s;
   logic [1:0]    nz_idx_s;
   logic          one_hot_s;

   assign init_s[0]   = init0;
   assign init_s[1]   = init1;
   assign init_s[2]   = init2;
   assign init_s[3]   = init3;
   assign pu_new_s[0] = pu_new0;
   assign pu_new_s[1] = pu_new1;
   assign pu_new_s[2] = pu_new2;
   assign pu_new_s[3] = pu_new3;
   assign pu_zero_s   = {pu_zero3, pu_zero2, pu_zero1, pu_zero0};

   nz_encoder u_nz_encoder (
      .zf      (zf_q),
      .nz      (nz_s),
      .idx     (nz_idx_s),
      .one_hot (one_hot_s)
   );

   // next-state, datapath and result computation
   always_comb begin
      state_d  = state_q;
      zf_d     = zf_q;
      iter_d   = iter_q;
      winner_d = winner_q;
      wv_d     = wv_q;
      to_d     = to_q;
      for (int i = 0; i < NLANES; i++) begin
         x_d[i] = x_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               for (int i = 0; i < NLANES; i++) begin
                  x_d[i] = init_s[i];
               end
               iter_d   = '0;
               to_d     = 1'b0;
               winner_d = 2'd0;
               wv_d     = 1'b0;
               state_d  = ST_MULT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MULT: begin
            state_d = ST_ADD;
         end
         ST_ADD: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            for (int i = 0; i < NLANES; i++) begin
               x_d[i] = pu_new_s[i];
            end
            zf_d = pu_zero_s;
            // saturate so the counter can never wrap past the limit
            if (iter_q < MAX_ITER_C) begin
               iter_d = iter_q + {{(IW-1){1'b0}}, 1'b1};
            end else begin
               iter_d = iter_q;
            end
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (nz_s <= 3'd1) begin
               wv_d     = one_hot_s;
               winner_d = one_hot_s ? nz_idx_s : 2'd0;
               state_d  = ST_DONE;
            end else if (iter_q >= MAX_ITER_C) begin
               to_d     = 1'b1;
               wv_d     = 1'b0;
               winner_d = 2'd0;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_MULT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // strobes are registered from the state being entered
      mult_d = (state_d == ST_MULT);
      add_d  = (state_d == ST_ADD);
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         zf_q     <= 4'b0000;
         iter_q   <= '0;
         winner_q <= 2'd0;
         wv_q     <= 1'b0;
         to_q     <= 1'b0;
         mult_q   <= 1'b0;
         add_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         for (int i = 0; i < NLANES; i++) begin
            x_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         zf_q     <= zf_d;
         iter_q   <= iter_d;
         winner_q <= winner_d;
         wv_q     <= wv_d;
         to_q     <= to_d;
         mult_q   <= mult_d;
         add_q    <= add_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         for (int i = 0; i < NLANES; i++) begin
            x_q[i] <= x_d[i];
         end
      end
   end

   assign x0           = x_q[0];
   assign x1           = x_q[1];
   assign x2           = x_q[2];
   assign x3           = x_q[3];
   assign mult_reg_en  = mult_q;
   assign add_reg_en   = add_q;
   assign done         = done_q;
   assign busy         = busy_q;
   assign winner       = winner_q;
   assign winner_valid = wv_q;
   assign timeout      = to_q;
   assign iter_count   = iter_q;

endmodule
